// File: rtl/half_duplex_bus_ctrl_pkg.sv
// Shared types for the half-duplex bus direction controller.
// State encoding and the direction flag used to decide when a turnaround is due.
package half_duplex_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAP_TX = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_GAP_RX = 3'd3,
        ST_SAMPLE = 3'd4
    } state_t;

    localparam logic DIR_TX = 1'b1;
    localparam logic DIR_RX = 1'b0;

endpackage

// File: rtl/half_duplex_bus_ctrl_turn_counter.sv
// Turnaround gap timer: reloads TURN while idle and counts down during a gap.
// With TURN=0 the gap never occurs, so done is held high.
module turn_counter #(
    parameter int TURN = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam int CW = (TURN > 0) ? $clog2(TURN + 1) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TURN);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // cnt==1 marks the last of the TURN gap cycles
    assign done = (TURN == 0) || (cnt == CW'(1));

endmodule

// File: rtl/half_duplex_bus_ctrl.sv
// Direction controller for a shared tristate bus: serialises writes and reads and
// keeps the bus released for TURN cycles whenever the transfer direction flips.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a request; tx_ready high
// GAP_TX    | bus released before a write after a read (TURN cycles)
// DRIVE     | bus_oe high, bus_out carries the write data (1 cycle)
// GAP_RX    | bus released before a read after a write (TURN cycles)
// SAMPLE    | bus released, bus_in captured into rx_data at cycle end
module half_duplex_bus_ctrl
    import half_duplex_bus_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TURN  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             rx_req,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic [WIDTH-1:0] bus_in
);

    localparam bit HAS_GAP = (TURN > 0);

    state_t           state, next_state;
    logic             last_dir;
    logic [WIDTH-1:0] data_q;
    logic             gap_done;

    turn_counter #(.TURN(TURN)) u_turn (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == ST_IDLE),
        .done  (gap_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    next_state = (last_dir == DIR_RX && HAS_GAP) ? ST_GAP_TX : ST_DRIVE;
                end else if (rx_req) begin
                    next_state = (last_dir == DIR_TX && HAS_GAP) ? ST_GAP_RX : ST_SAMPLE;
                end
            end
            ST_GAP_TX: if (gap_done) next_state = ST_DRIVE;
            ST_GAP_RX: if (gap_done) next_state = ST_SAMPLE;
            ST_DRIVE:  next_state = ST_IDLE;
            ST_SAMPLE: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // bus_out only changes on entry to DRIVE so it holds while the bus is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dir <= DIR_RX;
            data_q   <= '0;
            bus_out  <= '0;
            bus_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            bus_oe   <= (next_state == ST_DRIVE);
            rx_valid <= (state == ST_SAMPLE);
            if (state == ST_IDLE && tx_valid) begin
                data_q <= tx_data;
            end
            if (next_state == ST_DRIVE) begin
                bus_out <= (state == ST_IDLE) ? tx_data : data_q;
            end
            if (state == ST_SAMPLE) begin
                rx_data  <= bus_in;
                last_dir <= DIR_RX;
            end
            if (state == ST_DRIVE) begin
                last_dir <= DIR_TX;
            end
        end
    end

    assign tx_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_half_duplex_bus_ctrl.sv
// Directed bench for half_duplex_bus_ctrl: one instance with TURN=2, one with TURN=0.
module tb_half_duplex_bus_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;

    logic [WIDTH-1:0] tx_data = '0, bus_in = '0;
    logic             tx_valid = 1'b0, rx_req = 1'b0;
    logic             tx_ready, rx_valid, bus_oe;
    logic [WIDTH-1:0] rx_data, bus_out;

    logic [WIDTH-1:0] tx_data_z = '0, bus_in_z = '0;
    logic             tx_valid_z = 1'b0, rx_req_z = 1'b0;
    logic             tx_ready_z, rx_valid_z, bus_oe_z;
    logic [WIDTH-1:0] rx_data_z, bus_out_z;

    logic prev_oe, prev_oe_z;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    half_duplex_bus_ctrl #(.WIDTH(WIDTH), .TURN(2)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_req(rx_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    half_duplex_bus_ctrl #(.WIDTH(WIDTH), .TURN(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_z), .tx_valid(tx_valid_z),
        .tx_ready(tx_ready_z), .rx_req(rx_req_z), .rx_data(rx_data_z),
        .rx_valid(rx_valid_z), .bus_out(bus_out_z), .bus_oe(bus_oe_z), .bus_in(bus_in_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // advance one edge, sample 1ns later, and check no back-to-back drive pulses
    task automatic step();
        prev_oe   = bus_oe;
        prev_oe_z = bus_oe_z;
        @(posedge clk);
        #1;
        check("oe_no_double", 32'(prev_oe & bus_oe), 32'd0);
        check("oe_z_no_double", 32'(prev_oe_z & bus_oe_z), 32'd0);
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset state
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_oe", 32'(bus_oe), 32'd0);
        check("rst_bus_out", 32'(bus_out), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h0);

        // 1: first write after reset pays the 2-cycle gap
        tx_valid = 1'b1; tx_data = 8'hA5;
        step(); tx_valid = 1'b0; tx_data = 8'h00;
        check("t1_gap1_oe", 32'(bus_oe), 32'd0);
        check("t1_gap1_ready", 32'(tx_ready), 32'd0);
        step();
        check("t1_gap2_oe", 32'(bus_oe), 32'd0);
        check("t1_gap2_bus_out", 32'(bus_out), 32'h0);
        step();
        check("t1_drive_oe", 32'(bus_oe), 32'd1);
        check("t1_drive_data", 32'(bus_out), 32'hA5);
        step();
        check("t1_idle_oe", 32'(bus_oe), 32'd0);
        check("t1_hold_data", 32'(bus_out), 32'hA5);
        check("t1_idle_ready", 32'(tx_ready), 32'd1);

        // 2: back-to-back writes, no gap
        tx_valid = 1'b1; tx_data = 8'h11;
        step(); tx_data = 8'h22;
        check("t2_d1_oe", 32'(bus_oe), 32'd1);
        check("t2_d1_data", 32'(bus_out), 32'h11);
        check("t2_d1_ready", 32'(tx_ready), 32'd0);
        step();
        check("t2_idle_oe", 32'(bus_oe), 32'd0);
        step(); tx_valid = 1'b0;
        check("t2_d2_oe", 32'(bus_oe), 32'd1);
        check("t2_d2_data", 32'(bus_out), 32'h22);
        step();
        check("t2_end_oe", 32'(bus_oe), 32'd0);

        // 3: write then read, gap after DRIVE, rx_req dropped mid-gap
        tx_valid = 1'b1; tx_data = 8'h3C;
        step(); tx_valid = 1'b0; rx_req = 1'b1; bus_in = 8'hC3;
        check("t3_drive_data", 32'(bus_out), 32'h3C);
        step();
        check("t3_idle_oe", 32'(bus_oe), 32'd0);
        step(); rx_req = 1'b0;
        check("t3_gap1_oe", 32'(bus_oe), 32'd0);
        check("t3_gap1_ready", 32'(tx_ready), 32'd0);
        step();
        check("t3_gap2_rxv", 32'(rx_valid), 32'd0);
        step();
        check("t3_sample_oe", 32'(bus_oe), 32'd0);
        check("t3_sample_rxv", 32'(rx_valid), 32'd0);
        step(); bus_in = 8'h00;
        check("t3_rx_valid", 32'(rx_valid), 32'd1);
        check("t3_rx_data", 32'(rx_data), 32'hC3);
        step();
        check("t3_rx_valid_drop", 32'(rx_valid), 32'd0);
        check("t3_rx_data_hold", 32'(rx_data), 32'hC3);

        // 4: simultaneous requests, write first then read
        tx_valid = 1'b1; tx_data = 8'h5A; rx_req = 1'b1; bus_in = 8'h77;
        step(); tx_valid = 1'b0;
        check("t4_gaptx1_oe", 32'(bus_oe), 32'd0);
        step();
        check("t4_gaptx2_oe", 32'(bus_oe), 32'd0);
        step();
        check("t4_drive_oe", 32'(bus_oe), 32'd1);
        check("t4_drive_data", 32'(bus_out), 32'h5A);
        step();
        check("t4_idle_oe", 32'(bus_oe), 32'd0);
        step(); rx_req = 1'b0;
        check("t4_gaprx1_oe", 32'(bus_oe), 32'd0);
        step();
        check("t4_gaprx2_oe", 32'(bus_oe), 32'd0);
        step();
        check("t4_sample_oe", 32'(bus_oe), 32'd0);
        step();
        check("t4_rx_valid", 32'(rx_valid), 32'd1);
        check("t4_rx_data", 32'(rx_data), 32'h77);

        // 5: async reset in the middle of DRIVE
        tx_valid = 1'b1; tx_data = 8'h99;
        step(); tx_valid = 1'b0;
        step();
        step();
        check("t5_drive_oe", 32'(bus_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_oe", 32'(bus_oe), 32'd0);
        check("t5_async_bus_out", 32'(bus_out), 32'h0);
        check("t5_async_ready", 32'(tx_ready), 32'd1);
        #3 rst_n = 1'b1;
        step();
        check("t5_post_ready", 32'(tx_ready), 32'd1);
        check("t5_post_rxv", 32'(rx_valid), 32'd0);
        check("t5_post_oe", 32'(bus_oe), 32'd0);

        // 6: TURN=0, write then read with no gap
        tx_valid_z = 1'b1; tx_data_z = 8'h6E;
        step(); tx_valid_z = 1'b0; rx_req_z = 1'b1; bus_in_z = 8'hE6;
        check("t6_drive_oe", 32'(bus_oe_z), 32'd1);
        check("t6_drive_data", 32'(bus_out_z), 32'h6E);
        step();
        check("t6_idle_oe", 32'(bus_oe_z), 32'd0);
        check("t6_idle_ready", 32'(tx_ready_z), 32'd1);
        step(); rx_req_z = 1'b0;
        check("t6_sample_ready", 32'(tx_ready_z), 32'd0);
        check("t6_sample_oe", 32'(bus_oe_z), 32'd0);
        step();
        check("t6_rx_valid", 32'(rx_valid_z), 32'd1);
        check("t6_rx_data", 32'(rx_data_z), 32'hE6);
        step();
        check("t6_rx_valid_drop", 32'(rx_valid_z), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
